// File: rtl/l1_dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one fixed-latency dmem port between NUM_REQ L1 data caches.
// Define L1_SNOOP_INV_EN to add the snoop_inv/snoop_addr write-invalidate outputs.
module l1_dmem_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
`ifdef L1_SNOOP_INV_EN
  ,
  output logic [NUM_REQ-1:0]          snoop_inv,
  output logic [ADDR_W-1:0]           snoop_addr
`endif
);

  localparam int unsigned OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               state;
  state_t               state_next;
  logic [OWN_W-1:0]     rr_ptr;
  logic [OWN_W-1:0]     owner;
  logic [OWN_W-1:0]     winner;
  logic [OWN_W-1:0]     offset;
  logic [OWN_W:0]       win_sum;
  logic [CNT_W-1:0]     cnt;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;

  // Rotate requests so rr_ptr sits at bit 0, then take the lowest set bit.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[{1'b0, rr_ptr} +: NUM_REQ];

  always_comb begin
    offset = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = OWN_W'(i);
    end
  end

  assign win_sum = {1'b0, rr_ptr} + {1'b0, offset};
  assign winner  = (win_sum >= (OWN_W+1)'(NUM_REQ)) ? OWN_W'(win_sum - (OWN_W+1)'(NUM_REQ))
                                                    : OWN_W'(win_sum);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = ACCESS;
      ACCESS:  if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: mem_* hold the winner's latched request for the whole access window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr     <= '0;
      owner      <= '0;
      cnt        <= '0;
      gnt        <= '0;
      done       <= '0;
      rdata      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
`ifdef L1_SNOOP_INV_EN
      snoop_inv  <= '0;
      snoop_addr <= '0;
`endif
    end else begin
      gnt  <= '0;
      done <= '0;
      busy <= (state_next != IDLE);
`ifdef L1_SNOOP_INV_EN
      snoop_inv  <= '0;
      snoop_addr <= '0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            owner     <= winner;
            cnt       <= CNT_W'(MEM_LAT - 1);
            gnt       <= NUM_REQ'(1) << winner;
            mem_en    <= 1'b1;
            mem_we    <= req_we[winner];
            mem_addr  <= req_addr[winner*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[winner*DATA_W +: DATA_W];
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            rdata     <= mem_we ? '0 : mem_rdata;
            done      <= NUM_REQ'(1) << owner;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef L1_SNOOP_INV_EN
            if (mem_we) begin
              snoop_inv  <= ~(NUM_REQ'(1) << owner);
              snoop_addr <= mem_addr;
            end
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          rr_ptr <= (owner == OWN_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_dmem_arbiter.sv
// Bench for l1_dmem_arbiter: directed literal cases plus randomized traffic against a transaction-age model.
module tb_l1_dmem_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MEM_LAT = 2;
  localparam int          BOUND   = int'(NUM_REQ) * (int'(MEM_LAT) + 2) + 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req, req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt, done;
  logic [DATA_W-1:0]         rdata, mem_wdata, mem_rdata;
  logic                      mem_en, mem_we, busy;
  logic [ADDR_W-1:0]         mem_addr;
`ifdef L1_SNOOP_INV_EN
  logic [NUM_REQ-1:0]        snoop_inv;
  logic [ADDR_W-1:0]         snoop_addr;
`endif

  l1_dmem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
`ifdef L1_SNOOP_INV_EN
    , .snoop_inv(snoop_inv), .snoop_addr(snoop_addr)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int o);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[o] = 1'b1;
    return v;
  endfunction

  // Model: one transaction at a time, described by its age (1 = grant cycle).
  bit                m_active   = 1'b0;
  bit                m_in_reset = 1'b0;
  bit                m_found;
  bit                m_we       = 1'b0;
  int                m_age      = 0;
  int                m_owner    = 0;
  int                m_rr       = 0;
  int                m_c;
  logic [ADDR_W-1:0] m_addr     = '0;
  logic [DATA_W-1:0] m_wdata    = '0;
  logic [DATA_W-1:0] m_rdata    = '0;

  always @(posedge clk) begin
    if (!reset) begin
      m_active = 1'b0; m_age = 0; m_rr = 0; m_rdata = '0; m_in_reset = 1'b1;
    end else begin
      m_in_reset = 1'b0;
      if (!m_active) begin
        if (req != '0) begin
          m_found = 1'b0;
          for (int k = 0; k < int'(NUM_REQ); k++) begin
            m_c = (m_rr + k) % int'(NUM_REQ);
            if (!m_found && req[m_c]) begin m_found = 1'b1; m_owner = m_c; end
          end
          m_we     = req_we[m_owner];
          m_addr   = req_addr[m_owner*ADDR_W +: ADDR_W];
          m_wdata  = req_wdata[m_owner*DATA_W +: DATA_W];
          m_active = 1'b1;
          m_age    = 1;
        end
      end else begin
        if (m_age == int'(MEM_LAT)) m_rdata = m_we ? '0 : mem_rdata;
        if (m_age == int'(MEM_LAT) + 1) begin
          m_active = 1'b0; m_age = 0; m_rr = (m_owner + 1) % int'(NUM_REQ);
        end else begin
          m_age++;
        end
      end
    end
  end

  // Compare every cycle on the falling edge; also latch gnt/done for the requesters.
  logic [NUM_REQ-1:0] gnt_q = '0, done_q = '0;
  logic [NUM_REQ-1:0] e_gnt, e_done, e_inv;
  bit                 e_en;

  always @(negedge clk) begin
    e_en   = m_active && (m_age <= int'(MEM_LAT));
    e_gnt  = (m_active && m_age == 1) ? onehot(m_owner) : '0;
    e_done = (m_active && m_age == int'(MEM_LAT) + 1) ? onehot(m_owner) : '0;
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("done", 64'(done), 64'(e_done));
    chk("mem_en", 64'(mem_en), 64'(e_en));
    chk("busy", 64'(busy), 64'(m_active));
    chk("rdata", 64'(rdata), 64'(m_rdata));
    if (e_en) begin
      chk("mem_we", 64'(mem_we), 64'(m_we));
      chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    if (m_in_reset) begin
      chk("rst_mem_we", 64'(mem_we), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    end
`ifdef L1_SNOOP_INV_EN
    e_inv = (e_done != '0 && m_we) ? ~onehot(m_owner) : '0;
    chk("snoop_inv", 64'(snoop_inv), 64'(e_inv));
    chk("snoop_addr", 64'(snoop_addr), 64'((e_inv != '0) ? m_addr : '0));
`endif
    gnt_q  = gnt;
    done_q = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata = $urandom;
  endtask

  task automatic set_core(input int i, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic drain();
    int n = 0;
    while ((req != '0 || busy) && n < 50) begin
      tick();
      for (int i = 0; i < int'(NUM_REQ); i++) if (done_q[i]) req[i] = 1'b0;
      n++;
    end
    chk("drain_idle", 64'(req == '0 && !busy), 64'(1));
  endtask

  bit [NUM_REQ-1:0] pend = '0, granted = '0;
  int               wait_cnt [NUM_REQ];

  task automatic new_req(input int i);
    set_core(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom));
    pend[i] = 1'b1; granted[i] = 1'b0; wait_cnt[i] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; mem_rdata = '0;

    // Reset, then idle
    tick(); tick();
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_en", 64'(mem_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    reset = 1'b1;
    repeat (5) begin tick(); @(negedge clk); chk("idle_en", 64'(mem_en), 64'(0)); end

    // Single read by core0
    tick(); set_core(0, 1'b0, 10'h084, '0);
    tick(); @(negedge clk);
    chk("rd_gnt", 64'(gnt), 64'(2'b01));
    chk("rd_en1", 64'(mem_en), 64'(1));
    chk("rd_addr1", 64'(mem_addr), 64'(10'h084));
    tick(); mem_rdata = 32'hDEADBEEF; req_addr[0 +: ADDR_W] = 10'h3AA;
    @(negedge clk);
    chk("rd_en2", 64'(mem_en), 64'(1));
    chk("rd_addr2", 64'(mem_addr), 64'(10'h084));
    tick(); @(negedge clk);
    chk("rd_done", 64'(done), 64'(2'b01));
    chk("rd_rdata", 64'(rdata), 64'(32'hDEADBEEF));
    chk("rd_en3", 64'(mem_en), 64'(0));
    tick(); req[0] = 1'b0;

    // Single write by core1
    tick(); set_core(1, 1'b1, 10'h3FC, 32'h12345678);
    tick(); @(negedge clk);
    chk("wr_gnt", 64'(gnt), 64'(2'b10));
    chk("wr_we1", 64'(mem_we), 64'(1));
    chk("wr_wdata1", 64'(mem_wdata), 64'(32'h12345678));
    chk("wr_addr1", 64'(mem_addr), 64'(10'h3FC));
    tick(); @(negedge clk);
    chk("wr_we2", 64'(mem_we), 64'(1));
    tick(); @(negedge clk);
    chk("wr_done", 64'(done), 64'(2'b10));
    chk("wr_rdata", 64'(rdata), 64'(0));
    tick(); req[1] = 1'b0;

    // Simultaneous requests straight out of reset; both keep re-requesting
    reset = 1'b0; tick(); tick(); reset = 1'b1;
    set_core(0, 1'b0, 10'h011, '0); set_core(1, 1'b0, 10'h022, '0);
    tick(); @(negedge clk); chk("sim_gnt0", 64'(gnt), 64'(2'b01));
    tick(); tick(); @(negedge clk); chk("sim_done0", 64'(done), 64'(2'b01));
    tick(); req_addr[0 +: ADDR_W] = 10'h033;
    tick(); @(negedge clk);
    chk("sim_gnt1", 64'(gnt), 64'(2'b10));
    chk("sim_addr1", 64'(mem_addr), 64'(10'h022));
    tick(); tick(); @(negedge clk); chk("sim_done1", 64'(done), 64'(2'b10));
    tick(); tick(); @(negedge clk);
    chk("sim_gnt2", 64'(gnt), 64'(2'b01));
    chk("sim_addr2", 64'(mem_addr), 64'(10'h033));
    req[1] = 1'b0;
    drain();

    // Reset in the middle of an access aborts it and clears rr_ptr
    tick(); set_core(1, 1'b0, 10'h155, '0);
    tick(); @(negedge clk); chk("ab_gnt", 64'(gnt), 64'(2'b10));
    tick(); reset = 1'b0;
    tick(); reset = 1'b1; req = '0;
    @(negedge clk);
    chk("ab_en", 64'(mem_en), 64'(0));
    chk("ab_done", 64'(done), 64'(0));
    chk("ab_busy", 64'(busy), 64'(0));
    tick(); @(negedge clk); chk("ab_done2", 64'(done), 64'(0));
    tick(); set_core(0, 1'b0, 10'h0AA, '0); set_core(1, 1'b0, 10'h0BB, '0);
    tick(); @(negedge clk); chk("ab_rr0", 64'(gnt), 64'(2'b01));
    drain();

`ifdef L1_SNOOP_INV_EN
    tick(); set_core(0, 1'b1, 10'h040, 32'hA5A50001);
    tick(); @(negedge clk); chk("sn_inv_gnt", 64'(snoop_inv), 64'(0));
    tick(); tick(); @(negedge clk);
    chk("sn_done", 64'(done), 64'(2'b01));
    chk("sn_inv", 64'(snoop_inv), 64'(2'b10));
    chk("sn_addr", 64'(snoop_addr), 64'(10'h040));
    tick(); req[0] = 1'b0; @(negedge clk);
    chk("sn_inv_after", 64'(snoop_inv), 64'(0));
    chk("sn_addr_after", 64'(snoop_addr), 64'(0));
    tick(); set_core(1, 1'b0, 10'h040, '0);
    tick(); tick(); tick(); @(negedge clk);
    chk("sn_rd_done", 64'(done), 64'(2'b10));
    chk("sn_rd_inv", 64'(snoop_inv), 64'(0));
    drain();
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0; req = '0; pend = '0; granted = '0;
      end else begin
        reset = 1'b1;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
          if (pend[i] && !granted[i]) begin
            if (gnt_q[i]) begin
              chk("fair_wait", 64'(wait_cnt[i] <= BOUND), 64'(1));
              granted[i] = 1'b1;
            end else begin
              wait_cnt[i]++;
              if (wait_cnt[i] == BOUND + 1) chk("starved", 64'(wait_cnt[i]), 64'(BOUND));
            end
          end
          if (pend[i] && done_q[i]) begin
            pend[i] = 1'b0; granted[i] = 1'b0;
            if ($urandom_range(0, 1) == 1) new_req(i);
            else req[i] = 1'b0;
          end else if (!pend[i]) begin
            if ($urandom_range(0, 2) == 0) new_req(i);
          end else if (granted[i]) begin
            req_we[i] = 1'($urandom_range(0, 1));
            req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
            req_wdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
          end
        end
      end
    end
    reset = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
